// File: rtl/gcd_seq.sv
// gcd_seq: multi-cycle binary (Stein) GCD engine with valid/ready in and out
module gcd_seq #(
    parameter int WIDTH = 32,
    localparam int KW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic             coprime
);
    typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] x, y;
    logic [KW-1:0] k;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            k       <= '0;
            gcd     <= '0;
            coprime <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (a == '0 || b == '0) begin
                        gcd     <= a | b;
                        coprime <= (a | b) == WIDTH'(1);
                        state   <= DONE;
                    end else begin
                        x     <= a;
                        y     <= b;
                        k     <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: if (!x[0] && !y[0]) begin
                    x <= x >> 1;
                    y <= y >> 1;
                    k <= k + 1'b1;
                end else begin
                    state <= REDUCE;
                end
                REDUCE: if (!x[0]) x <= x >> 1;
                else if (!y[0]) y <= y >> 1;
                else if (x == y) begin
                    gcd     <= x << k;
                    coprime <= (x << k) == WIDTH'(1);
                    state   <= DONE;
                end
                else if (x > y) x <= (x - y) >> 1;
                else y <= (y - x) >> 1;
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_seq.sv
// tb_gcd_seq: scoreboard bench for gcd_seq at WIDTH 32, 16 and 8
module tb_gcd_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic iv, ordy;
    logic [1:0] sel;
    logic [63:0] av, bv;
    logic ir0, ir1, ir2, ov0, ov1, ov2, cp0, cp1, cp2;
    logic [31:0] g0;
    logic [15:0] g1;
    logic [7:0] g2;
    logic [63:0] g;
    logic ir, ov, cp;
    int checks = 0;
    int errors = 0;
    typedef struct {logic [63:0] g; logic c;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    gcd_seq #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd0), .in_ready(ir0),
        .a(av[31:0]), .b(bv[31:0]), .out_valid(ov0), .out_ready(ordy), .gcd(g0), .coprime(cp0));
    gcd_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd1), .in_ready(ir1),
        .a(av[15:0]), .b(bv[15:0]), .out_valid(ov1), .out_ready(ordy), .gcd(g1), .coprime(cp1));
    gcd_seq #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd2), .in_ready(ir2),
        .a(av[7:0]), .b(bv[7:0]), .out_valid(ov2), .out_ready(ordy), .gcd(g2), .coprime(cp2));

    assign g  = sel == 2'd0 ? 64'(g0) : sel == 2'd1 ? 64'(g1) : 64'(g2);
    assign ir = sel == 2'd0 ? ir0 : sel == 2'd1 ? ir1 : ir2;
    assign ov = sel == 2'd0 ? ov0 : sel == 2'd1 ? ov1 : ov2;
    assign cp = sel == 2'd0 ? cp0 : sel == 2'd1 ? cp1 : cp2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_gcd(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic run(input logic [1:0] s, input logic [63:0] x, input logic [63:0] y,
                       input int elat, input int hold);
        int w, lat;
        exp_t e;
        w = s == 2'd0 ? 32 : s == 2'd1 ? 16 : 8;
        sel = s;
        av = x;
        bv = y;
        #1;
        chk("in_ready_idle", 64'(ir), 1);
        e.g = ref_gcd(x, y);
        e.c = e.g == 1;
        q.push_back(e);
        iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 2 * w + 10) begin
            chk("in_ready_busy", 64'(ir), 0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid", 64'(ov), 1);
        chk("in_ready_done", 64'(ir), 0);
        if (elat >= 0) chk("latency", 64'(lat), 64'(elat));
        chk("latency_bound", 64'(lat <= 2 * w + 2), 1);
        e = q.pop_front();
        chk("gcd", g, e.g);
        chk("coprime", 64'(cp), 64'(e.c));
        for (int i = 0; i < hold; i++) begin
            av = ~x;
            bv = 64'd3;
            iv = i[0];
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(ov), 1);
            chk("bp_gcd", g, e.g);
            chk("bp_coprime", 64'(cp), 64'(e.c));
            chk("bp_ready", 64'(ir), 0);
        end
        iv = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        chk("release_valid", 64'(ov), 0);
        chk("release_ready", 64'(ir), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] x, y, m;
        rst_n = 1'b0;
        iv = 1'b0;
        ordy = 1'b0;
        sel = 2'd0;
        av = '0;
        bv = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov), 0);
        chk("rst_in_ready", 64'(ir), 1);
        chk("rst_gcd", g, 0);
        chk("rst_coprime", 64'(cp), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(2'd0, 48, 18, 7, 0);
        run(2'd0, 123456789, 987654321, -1, 0);
        run(2'd0, 987654321, 123456789, -1, 0);
        run(2'd0, 0, 35, 0, 0);
        run(2'd0, 35, 0, 0, 0);
        run(2'd0, 0, 0, 0, 0);
        run(2'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, -1, 0);
        run(2'd0, 64'h8000_0000, 64'h4000_0000, -1, 0);
        run(2'd0, 17, 4, -1, 0);
        run(2'd0, 1071, 462, -1, 10);
        run(2'd0, 100, 75, -1, 0);
        // abort a computation part-way through and confirm a clean restart
        sel = 2'd0;
        av = 48;
        bv = 18;
        iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(ov), 0);
        chk("abort_in_ready", 64'(ir), 1);
        chk("abort_gcd", g, 0);
        chk("abort_coprime", 64'(cp), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(2'd0, 21, 14, -1, 0);
        for (int s = 1; s <= 2; s++) begin
            m = s == 1 ? 64'hFFFF : 64'hFF;
            for (int n = 0; n < 1000; n++) begin
                x = $urandom_range(0, 9) == 0 ? 64'd0 : 64'($urandom) & m;
                y = $urandom_range(0, 9) == 0 ? 64'd0 : 64'($urandom) & m;
                run(2'(s), x, y, -1, 0);
            end
        end
        chk("scoreboard_empty", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
